// File: rtl/pix_pkg.sv
// Shared types and constants for the colorbar pattern scheduler.
// Holds the pattern index width, the step saturation limit and the scheduler FSM states.
package pix_pkg;

    localparam int PIX_W    = 4;
    localparam int STEP_MAX = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        APPLY = 2'd2
    } sched_state_t;

endpackage

// File: rtl/key_debounce.sv
// Purpose: 2-FF synchronizer plus saturating debounce counter; one key_evt pulse per valid press.
// Latency: key_evt rises DEBOUNCE_CYC+2 cycles after the key falls.
// Backpressure: none; free-running, key_evt is a single-cycle pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_evt
);

    localparam int CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    logic          key_s1;
    logic          key_s2;
    logic          done;
    logic [CW-1:0] cnt;

    // done marks that this press already fired, so long holds yield a single event
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            key_s1  <= 1'b1;
            key_s2  <= 1'b1;
            cnt     <= '0;
            done    <= 1'b0;
            key_evt <= 1'b0;
        end else begin
            key_s1 <= key_in;
            key_s2 <= key_s1;
            if (key_s2) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
            done    <= !key_s2 && (cnt == CNT_MAX);
            key_evt <= !key_s2 && (cnt == CNT_MAX) && !done;
        end
    end

endmodule

// File: rtl/pix_mode_sched.sv
// Purpose: queue pattern-advance requests and commit pix_num only at a frame start (AUTO_SLIDESHOW_EN adds a frame timer).
// Latency: pix_num and pix_update change one cycle after the frame start that ends PEND.
// Backpressure: none; up to STEP_MAX queued steps, further requests in the same frame saturate.
module pix_mode_sched
    import pix_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int NUM_MODES    = 4,
    parameter int AUTO_FRAMES  = 300,
    parameter int VS_POL       = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             key_in,
    input  logic             vsync_in,
    output logic [PIX_W-1:0] pix_num,
    output logic             pix_update,
    output logic             pending
);

    localparam logic VS_LVL = (VS_POL != 0);

    sched_state_t state;
    logic [1:0]   steps;
    logic [1:0]   steps_inc;
    logic         key_evt;
    logic         auto_evt;
    logic         vs_q;
    logic         fs;
    logic         req;

    key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_key_debounce (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .key_in  (key_in),
        .key_evt (key_evt)
    );

    // vs_q resets to the active level so a high vsync at reset release is not a frame start
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            vs_q <= VS_LVL;
        end else begin
            vs_q <= vsync_in;
        end
    end

    assign fs = (vsync_in == VS_LVL) && (vs_q != VS_LVL);

`ifdef AUTO_SLIDESHOW_EN
    localparam int FW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

    logic [FW-1:0] frame_cnt;

    assign auto_evt = fs && (frame_cnt == FW'(AUTO_FRAMES - 1));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            frame_cnt <= '0;
        end else if (key_evt || auto_evt) begin
            frame_cnt <= '0;
        end else if (fs) begin
            frame_cnt <= frame_cnt + FW'(1);
        end
    end
`else
    logic unused_auto_cfg;

    assign unused_auto_cfg = (AUTO_FRAMES != 0);
    assign auto_evt        = 1'b0;
`endif

    assign req       = key_evt || auto_evt;
    assign steps_inc = (steps == 2'(STEP_MAX)) ? steps : steps + 2'd1;

    // Boot pattern 0 jumps straight to index steps; selectable patterns wrap within 1..NUM_MODES
    function automatic logic [PIX_W-1:0] next_pix(input logic [PIX_W-1:0] cur, input logic [1:0] st);
        logic [4:0] sum;
        sum = {1'b0, cur} - 5'd1 + {3'b000, st};
        if (cur == '0) begin
            return {2'b00, st};
        end
        return PIX_W'((sum % 5'(NUM_MODES)) + 5'd1);
    endfunction

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            steps      <= 2'd0;
            pix_num    <= '0;
            pix_update <= 1'b0;
            pending    <= 1'b0;
        end else begin
            pix_update <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        state   <= PEND;
                        steps   <= 2'd1;
                        pending <= 1'b1;
                    end
                end
                PEND: begin
                    if (req) begin
                        steps <= steps_inc;
                    end
                    if (fs) begin
                        state   <= APPLY;
                        pending <= 1'b0;
                    end
                end
                APPLY: begin
                    pix_num    <= next_pix(pix_num, steps);
                    pix_update <= 1'b1;
                    if (req) begin
                        state   <= PEND;
                        steps   <= 2'd1;
                        pending <= 1'b1;
                    end else begin
                        state <= IDLE;
                        steps <= 2'd0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    steps   <= 2'd0;
                    pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pix_mode_sched.sv
// Bench for pix_mode_sched: directed frame-boundary scenarios plus random presses against a reference model.
// Frame is 200 cycles with vsync high for the first 10; AUTO_SLIDESHOW_EN switches to the slideshow scenario.
module tb_pix_mode_sched;

    localparam int DC    = 16;
    localparam int NM    = 4;
    localparam int AF    = 3;
    localparam int FRAME = 200;

    logic       sys_clk;
    logic       sys_rst;
    logic       key_in;
    logic       vsync_in;
    logic [3:0] pix_num;
    logic       pix_update;
    logic       pending;

    int n_cmp = 0;
    int n_err = 0;
    int fc    = 0;
    int upd_cnt = 0;

    pix_mode_sched #(
        .DEBOUNCE_CYC (DC),
        .NUM_MODES    (NM),
        .AUTO_FRAMES  (AF),
        .VS_POL       (1)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .key_in     (key_in),
        .vsync_in   (vsync_in),
        .pix_num    (pix_num),
        .pix_update (pix_update),
        .pending    (pending)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        vsync_in = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            fc = (fc == FRAME - 1) ? 0 : fc + 1;
            vsync_in = (fc < 10);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: request counting and pattern arithmetic taken straight from the rules
    int m_pix, m_q, m_apply, m_run, m_fcnt;
    bit m_kevt, m_vprev, m_upd, r1, r2;

    always @(posedge sys_clk or posedge sys_rst) begin
        bit fs, req, aevt, s2v;
        if (sys_rst) begin
            m_pix = 0; m_q = 0; m_apply = 0; m_run = 0; m_fcnt = 0;
            m_kevt = 0; m_vprev = 1; m_upd = 0; r1 = 1; r2 = 1;
        end else begin
            fs      = vsync_in && !m_vprev;
            m_vprev = vsync_in;
            req     = m_kevt;
            aevt    = 0;
`ifdef AUTO_SLIDESHOW_EN
            aevt = fs && (m_fcnt == AF - 1);
            if (m_kevt || aevt) m_fcnt = 0;
            else if (fs) m_fcnt++;
`endif
            req   = req || aevt;
            m_upd = 0;
            if (m_apply > 0) begin
                m_pix   = (m_pix == 0) ? m_apply : ((m_pix - 1 + m_apply) % NM) + 1;
                m_upd   = 1;
                m_apply = 0;
                m_q     = req ? 1 : 0;
            end else if (m_q > 0) begin
                m_q = (m_q + int'(req) > 3) ? 3 : m_q + int'(req);
                if (fs) begin
                    m_apply = m_q;
                    m_q     = 0;
                end
            end else begin
                m_q = req ? 1 : 0;
            end
            // key event once the synchronized key has been low for DC consecutive samples
            s2v    = r2;
            r2     = r1;
            r1     = key_in;
            m_run  = s2v ? 0 : ((m_run < 1000) ? m_run + 1 : m_run);
            m_kevt = (m_run == DC);
        end
    end

    always @(negedge sys_clk) begin
        if (pix_update === 1'b1) upd_cnt++;
        if (!sys_rst) begin
            chk("pix_num", 32'(pix_num), 32'(m_pix));
            chk("pix_update", 32'(pix_update), 32'(m_upd));
            chk("pending", 32'(pending), 32'(m_q > 0));
        end
    end

    task automatic wait_fc(input int t);
        int n = 0;
        do begin
            @(posedge sys_clk);
            #2;
            n++;
        end while (fc != t && n < 2 * FRAME);
        chk("wait_fc", 32'(fc), 32'(t));
    endtask

    task automatic press(input int hold, input int gap);
        key_in = 1'b0;
        repeat (hold) @(posedge sys_clk);
        #2;
        key_in = 1'b1;
        repeat (gap) @(posedge sys_clk);
        #2;
    endtask

    initial begin
        int lat;
        int base;
        sys_rst = 1'b1;
        key_in  = 1'b1;
        repeat (3) @(posedge sys_clk);
        #2;
        chk("rst_pix_num", 32'(pix_num), 0);
        chk("rst_pix_update", 32'(pix_update), 0);
        chk("rst_pending", 32'(pending), 0);
        sys_rst = 1'b0;

`ifndef AUTO_SLIDESHOW_EN
        // long hold: one event, pending latency, commit at next frame
        wait_fc(20);
        base   = upd_cnt;
        key_in = 1'b0;
        lat    = 0;
        repeat (40) begin
            @(posedge sys_clk);
            lat++;
            @(negedge sys_clk);
            if (pending) break;
        end
        chk("pend_latency", 32'(lat), 19);
        repeat (100 - lat) @(posedge sys_clk);
        #2;
        key_in = 1'b1;
        wait_fc(20);
        chk("first_pix", 32'(pix_num), 1);
        chk("first_upd_cnt", 32'(upd_cnt - base), 1);

        // short glitches never register
        base = upd_cnt;
        repeat (5) press(10, 10);
        chk("glitch_pending", 32'(pending), 0);
        wait_fc(20);
        chk("glitch_pix", 32'(pix_num), 1);
        chk("glitch_upd_cnt", 32'(upd_cnt - base), 0);

        // four presses in one frame saturate at three steps
        press(25, 15);
        wait_fc(20);
        chk("pix_two", 32'(pix_num), 2);
        repeat (4) press(25, 15);
        wait_fc(20);
        chk("sat_pix", 32'(pix_num), 1);

        // reach the last pattern, then wrap
        repeat (3) press(25, 15);
        wait_fc(20);
        chk("pix_four", 32'(pix_num), 4);
        press(25, 15);
        wait_fc(20);
        chk("wrap_pix", 32'(pix_num), 1);

        // key event lands in the APPLY cycle: queued for the following frame
        press(25, 15);
        wait_fc(183);
        press(25, 15);
        chk("apply_hit_pix", 32'(pix_num), 2);
        chk("apply_hit_pending", 32'(pending), 1);
        wait_fc(20);
        chk("apply_next_pix", 32'(pix_num), 3);
        chk("apply_next_pending", 32'(pending), 0);

        // reset while a change is pending
        press(25, 15);
        chk("pre_rst_pending", 32'(pending), 1);
        sys_rst = 1'b1;
        #1;
        chk("mid_rst_pix", 32'(pix_num), 0);
        chk("mid_rst_pending", 32'(pending), 0);
        repeat (2) @(posedge sys_clk);
        #2;
        sys_rst = 1'b0;
        base    = upd_cnt;
        wait_fc(20);
        chk("post_rst_upd_cnt", 32'(upd_cnt - base), 0);
        chk("post_rst_pix", 32'(pix_num), 0);
`else
        // slideshow: 0->1->2->3->4->1, then a press mid-dwell restarts the timer
        base = upd_cnt;
        repeat (16 * FRAME) @(posedge sys_clk);
        #2;
        chk("auto_upd_cnt", 32'(upd_cnt - base), 5);
        wait_fc(220 % FRAME);
        press(25, 15);
        repeat (8 * FRAME) @(posedge sys_clk);
        #2;
`endif

        // random presses checked cycle by cycle against the model
        repeat (40) press($urandom_range(4, 40), $urandom_range(2, 80));
        repeat (2 * FRAME + 50) @(posedge sys_clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
